// File: rtl/uart_rx_if.sv
// RX FIFO write-side bundle: received byte, write strobe, error pulses and the FIFO full flag.
interface uart_rx_if;
  logic [7:0] data;
  logic       wr_en;
  logic       full;
  logic       frame_err;
  logic       overrun;

  modport master (output data, wr_en, frame_err, overrun, input full);
  modport slave  (input data, wr_en, frame_err, overrun, output full);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver (LSB first, mid-bit sampling), pushing bytes to the RX FIFO with a 1-cycle strobe.
// Strobe lands HALF_BIT+9*CLKS_PER_BIT+3 edges after RXD falls; full=1 at the stop sample drops the byte (overrun).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RXD,
  uart_rx_if.master   bus
);

  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [14:0] BIT_LAST  = 15'(CLKS_PER_BIT - 1);
  localparam logic [14:0] HALF_LAST = 15'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic        sync1;
  logic        rxd_s;
  logic        rxd_d;
  logic        fall;

  logic [2:0]  state;
  logic [14:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  logic [7:0]  data_q;
  logic        wr_en_q;
  logic        frame_err_q;
  logic        overrun_q;

  // Synchroniser and edge history reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      sync1 <= RXD;
      rxd_s <= sync1;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // A line that is back high at mid-start was only a glitch.
            if (!rxd_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 15'd1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rxd_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + 15'd1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
            if (rxd_s) begin
              state <= S_IDLE;
              if (!bus.full) begin
                data_q  <= shift;
                wr_en_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              state       <= S_BREAK;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 15'd1;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame stimulus for uart_rx; each frame's outcome and strobe cycle are predicted from the frame timing rules.
module tb_uart_rx;
  localparam int C    = 16;
  localparam int HALF = C / 2;

  localparam int K_WR   = 1;
  localparam int K_FERR = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] dat;
  } ev_t;

  logic clk;
  logic rst_n;
  logic RXD;
  int   cyc;
  int   n_checks;
  int   n_errors;
  logic [7:0] model_data;
  ev_t  exp_q[$];

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RXD   (RXD),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event scoreboard: every strobe must match the oldest predicted event, at its predicted cycle.
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_ev_cyc", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.wr_en || bus.frame_err || bus.overrun) begin
        kind = bus.wr_en ? K_WR : (bus.frame_err ? K_FERR : K_OVR);
        check("strobe_excl", 32'(bus.wr_en) + 32'(bus.frame_err) + 32'(bus.overrun), 1);
        if (exp_q.size() == 0) begin
          check("spurious_kind", kind, 0);
        end else begin
          e = exp_q.pop_front();
          check("ev_cyc", cyc, e.cyc);
          check("ev_kind", kind, e.kind);
          if (e.kind == K_WR) begin
            check("wr_data", bus.data, e.dat);
            model_data = e.dat;
          end else begin
            check("held_data", bus.data, model_data);
          end
        end
      end
    end
  end

  // All stimulus tasks start just after a posedge (#1) and return on a posedge.
  task automatic idle(input int n);
    #1;
    RXD      = 1'b1;
    bus.full = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic hold_low(input int n);
    #1;
    RXD = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic glitch(input int n);
    hold_low(n);
    idle(C);
  endtask

  task automatic check_reset_outputs();
    check("rst_data", bus.data, 8'h00);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun, 0);
  endtask

  // fmode: 0/1 hold full at that level during data bits, 2 randomise it per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic full_stop,
                            input int fmode, input int rst_bit);
    ev_t e;
    int  k;
    #1;
    RXD      = 1'b0;
    bus.full = 1'b0;
    k        = cyc + 1;
    if (rst_bit < 0) begin
      e.cyc  = k + 2 + HALF + 9 * C;
      e.kind = !stop_bit ? K_FERR : (full_stop ? K_OVR : K_WR);
      e.dat  = b;
      exp_q.push_back(e);
    end
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1;
      RXD      = b[i];
      bus.full = (fmode == 2) ? 1'($urandom_range(0, 1)) : (fmode == 1);
      if (i == rst_bit) begin
        repeat (HALF) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        RXD      = 1'b1;
        bus.full = 1'b0;
        model_data = 8'h00;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        return;
      end
      repeat (C) @(posedge clk);
    end
    #1;
    RXD      = stop_bit;
    bus.full = full_stop;
    repeat (C) @(posedge clk);
  endtask

  task automatic end_check(input string tag);
    idle(C);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_data"}, bus.data, model_data);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rst_ok;
    logic       rfs;
    n_checks   = 0;
    n_errors   = 0;
    model_data = 8'h00;
    rst_n      = 1'b0;
    RXD        = 1'b1;
    bus.full   = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    idle(4);

    send_frame(8'hA5, 1'b1, 1'b0, 0, -1);
    end_check("a5");

    send_frame(8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, 0, -1);
    send_frame(8'h3C, 1'b1, 1'b0, 0, -1);
    end_check("b2b");

    glitch(5);
    send_frame(8'h81, 1'b1, 1'b0, 0, -1);
    end_check("glitch");

    send_frame(8'h55, 1'b0, 1'b0, 0, -1);
    hold_low(100);
    idle(C);
    send_frame(8'h12, 1'b1, 1'b0, 0, -1);
    end_check("break");

    send_frame(8'h7E, 1'b1, 1'b1, 0, -1);
    end_check("ovr");
    send_frame(8'h6B, 1'b1, 1'b0, 1, -1);
    end_check("full_mid");

    send_frame(8'hC3, 1'b1, 1'b0, 0, 4);
    idle(C);
    check("rst_mid_pending", exp_q.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b0, 0, -1);
    end_check("after_rst");

    for (int it = 0; it < 40; it++) begin
      rb     = 8'($urandom);
      rst_ok = ($urandom_range(0, 7) != 0);
      rfs    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) glitch($urandom_range(1, HALF - 1));
      send_frame(rb, rst_ok, rfs, 2, -1);
      if (!rst_ok) idle($urandom_range(3, 40));
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 30));
    end
    end_check("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
